// File: rtl/laser_cover_search.sv
// Two-circle coverage searcher: loads N_OBJ points, then alternately sweeps one circle
// over the whole grid while the other is held, committing strict improvements.
module laser_cover_search #(
  parameter int COORD_W  = 4,
  parameter int N_OBJ    = 40,
  parameter int RADIUS   = 4,
  parameter int MAX_ITER = 15,
  parameter int CNT_W    = $clog2(N_OBJ + 1)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               VALID,
  input  logic [COORD_W-1:0] X,
  input  logic [COORD_W-1:0] Y,
  output logic               READY,
  output logic [COORD_W-1:0] C1X,
  output logic [COORD_W-1:0] C1Y,
  output logic [COORD_W-1:0] C2X,
  output logic [COORD_W-1:0] C2Y,
  output logic [CNT_W-1:0]   COUNT,
  output logic               DONE
);

  // state   | meaning
  // S_LOAD  | accepting points, READY high
  // S_SWEEP | scanning candidate centres for the moving circle, one point per cycle
  // S_UPDATE| commit sweep best if it strictly improves COUNT
  // S_FINISH| one-cycle DONE pulse
  typedef enum logic [1:0] {S_LOAD, S_SWEEP, S_UPDATE, S_FINISH} state_t;

  localparam int KW = $clog2(N_OBJ);
  localparam int IW = $clog2(MAX_ITER + 1);
  localparam int unsigned R2 = int'(RADIUS * RADIUS);
  localparam logic [KW-1:0] K_LAST = KW'(N_OBJ - 1);
  localparam logic [IW-1:0] ITER_CAP = IW'(MAX_ITER);
  localparam logic [COORD_W-1:0] POS_MAX = '1;

  state_t             state;
  logic [COORD_W-1:0] pts_x [N_OBJ];
  logic [COORD_W-1:0] pts_y [N_OBJ];
  logic [KW-1:0]      k;
  logic [COORD_W-1:0] cand_x, cand_y;
  logic [COORD_W-1:0] best_x, best_y;
  logic [CNT_W-1:0]   acc, best_cnt, acc_next;
  logic               moving;
  logic [IW-1:0]      iter;
  logic [COORD_W-1:0] fix_x, fix_y;
  logic               cov;

  function automatic logic covers(input logic [COORD_W-1:0] ax, input logic [COORD_W-1:0] ay,
                                  input logic [COORD_W-1:0] bx, input logic [COORD_W-1:0] by);
    logic [COORD_W-1:0]   dx, dy;
    logic [2*COORD_W-1:0] sx, sy;
    logic [2*COORD_W:0]   sum;
    dx  = (ax >= bx) ? ax - bx : bx - ax;
    dy  = (ay >= by) ? ay - by : by - ay;
    sx  = {{COORD_W{1'b0}}, dx} * {{COORD_W{1'b0}}, dx};
    sy  = {{COORD_W{1'b0}}, dy} * {{COORD_W{1'b0}}, dy};
    sum = {1'b0, sx} + {1'b0, sy};
    return 32'(sum) <= R2;
  endfunction

  // moving=0 sweeps circle 1 against committed circle 2, and vice versa
  assign fix_x    = moving ? C1X : C2X;
  assign fix_y    = moving ? C1Y : C2Y;
  assign cov      = covers(cand_x, cand_y, pts_x[k], pts_y[k]) | covers(fix_x, fix_y, pts_x[k], pts_y[k]);
  assign acc_next = acc + CNT_W'(cov);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_LOAD;
      READY    <= 1'b1;
      DONE     <= 1'b0;
      C1X      <= '0;
      C1Y      <= '0;
      C2X      <= '0;
      C2Y      <= '0;
      COUNT    <= '0;
      k        <= '0;
      cand_x   <= '0;
      cand_y   <= '0;
      best_x   <= '0;
      best_y   <= '0;
      best_cnt <= '0;
      acc      <= '0;
      moving   <= 1'b0;
      iter     <= '0;
      for (int i = 0; i < N_OBJ; i++) begin
        pts_x[i] <= '0;
        pts_y[i] <= '0;
      end
    end else begin
      case (state)
        S_LOAD: begin
          if (VALID) begin
            pts_x[k] <= X;
            pts_y[k] <= Y;
            if (k == '0) begin
              C1X   <= '0;
              C1Y   <= '0;
              C2X   <= '0;
              C2Y   <= '0;
              COUNT <= '0;
            end
            if (k == K_LAST) begin
              state  <= S_SWEEP;
              READY  <= 1'b0;
              k      <= '0;
              moving <= 1'b0;
              iter   <= '0;
            end else begin
              k <= k + KW'(1);
            end
          end
        end
        // candidate, accumulator and index all wrap back to zero at sweep end
        S_SWEEP: begin
          if (k == K_LAST) begin
            k   <= '0;
            acc <= '0;
            if (acc_next >= best_cnt) begin
              best_cnt <= acc_next;
              best_x   <= cand_x;
              best_y   <= cand_y;
            end
            cand_x <= cand_x + COORD_W'(1);
            if (cand_x == POS_MAX) begin
              cand_y <= cand_y + COORD_W'(1);
              if (cand_y == POS_MAX) state <= S_UPDATE;
            end
          end else begin
            k   <= k + KW'(1);
            acc <= acc_next;
          end
        end
        S_UPDATE: begin
          best_cnt <= '0;
          best_x   <= '0;
          best_y   <= '0;
          if (best_cnt > COUNT) begin
            if (moving) begin
              C2X <= best_x;
              C2Y <= best_y;
            end else begin
              C1X <= best_x;
              C1Y <= best_y;
            end
            COUNT <= best_cnt;
            iter  <= iter + IW'(1);
            if (iter + IW'(1) == ITER_CAP) begin
              state <= S_FINISH;
              DONE  <= 1'b1;
            end else begin
              moving <= ~moving;
              state  <= S_SWEEP;
            end
          end else begin
            state <= S_FINISH;
            DONE  <= 1'b1;
          end
        end
        S_FINISH: begin
          DONE  <= 1'b0;
          READY <= 1'b1;
          state <= S_LOAD;
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_laser_cover_search.sv
// Directed bench: default, MAX_ITER=1 and small radius-0 instances with hand-computed results.
module tb_laser_cover_search;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       d_valid, d_ready, d_done;
  logic [3:0] d_x, d_y, d_c1x, d_c1y, d_c2x, d_c2y;
  logic [5:0] d_count;

  logic       m_valid, m_ready, m_done;
  logic [3:0] m_x, m_y, m_c1x, m_c1y, m_c2x, m_c2y;
  logic [5:0] m_count;

  logic       s_valid, s_ready, s_done;
  logic [2:0] s_x, s_y, s_c1x, s_c1y, s_c2x, s_c2y;
  logic [2:0] s_count;

  int n_tests = 0;
  int n_fail  = 0;
  int tx [40];
  int ty [40];
  int sx [4] = '{1, 1, 1, 6};
  int sy [4] = '{1, 1, 1, 2};

  laser_cover_search u_d (
    .CLK(clk), .RST(rst), .VALID(d_valid), .X(d_x), .Y(d_y), .READY(d_ready),
    .C1X(d_c1x), .C1Y(d_c1y), .C2X(d_c2x), .C2Y(d_c2y), .COUNT(d_count), .DONE(d_done)
  );

  laser_cover_search #(.MAX_ITER(1)) u_m (
    .CLK(clk), .RST(rst), .VALID(m_valid), .X(m_x), .Y(m_y), .READY(m_ready),
    .C1X(m_c1x), .C1Y(m_c1y), .C2X(m_c2x), .C2Y(m_c2y), .COUNT(m_count), .DONE(m_done)
  );

  laser_cover_search #(.COORD_W(3), .N_OBJ(4), .RADIUS(0)) u_s (
    .CLK(clk), .RST(rst), .VALID(s_valid), .X(s_x), .Y(s_y), .READY(s_ready),
    .C1X(s_c1x), .C1Y(s_c1y), .C2X(s_c2x), .C2Y(s_c2y), .COUNT(s_count), .DONE(s_done)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load_d(input bit stall);
    for (int i = 0; i < 40; i++) begin
      d_valid = 1'b1;
      d_x = 4'(tx[i]);
      d_y = 4'(ty[i]);
      @(posedge clk); #1;
      if (i == 0) begin
        check("d_clr_count", int'(d_count), 0);
        check("d_clr_c1x", int'(d_c1x), 0);
      end
      if (i == 38) check("d_ready_before_last", int'(d_ready), 1);
      if (stall && i < 39) begin
        d_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    d_valid = 1'b0;
    check("d_ready_sweep", int'(d_ready), 0);
  endtask

  task automatic wait_d(input string tag, input int exp_lat, input int c1x, input int c1y,
                        input int c2x, input int c2y, input int cnt);
    int lat = 0;
    while (!d_done && lat < 25000) begin
      @(posedge clk); #1;
      lat++;
    end
    d_valid = 1'b0;
    if (!d_done) check({tag, "_timeout"}, int'(d_done), 1);
    else begin
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_c1x"}, int'(d_c1x), c1x);
      check({tag, "_c1y"}, int'(d_c1y), c1y);
      check({tag, "_c2x"}, int'(d_c2x), c2x);
      check({tag, "_c2y"}, int'(d_c2y), c2y);
      check({tag, "_count"}, int'(d_count), cnt);
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, int'(d_done), 0);
      check({tag, "_ready_after"}, int'(d_ready), 1);
    end
  endtask

  task automatic run_m();
    int lat = 0;
    for (int i = 0; i < 40; i++) begin
      m_valid = 1'b1;
      m_x = 4'd7;
      m_y = 4'd7;
      @(posedge clk); #1;
    end
    m_valid = 1'b0;
    while (!m_done && lat < 25000) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!m_done) check("m_timeout", int'(m_done), 1);
    else begin
      check("m_latency", lat, 10241);
      check("m_c1x", int'(m_c1x), 7);
      check("m_c1y", int'(m_c1y), 11);
      check("m_c2x", int'(m_c2x), 0);
      check("m_count", int'(m_count), 40);
    end
  endtask

  task automatic run_s();
    int lat = 0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_x = 3'(sx[i]);
      s_y = 3'(sy[i]);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    while (!s_done && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 257) begin
        check("s_sweep1_count", int'(s_count), 3);
        check("s_sweep1_c1x", int'(s_c1x), 1);
        check("s_sweep1_c1y", int'(s_c1y), 1);
      end
      if (lat == 514) begin
        check("s_sweep2_count", int'(s_count), 4);
        check("s_sweep2_c2x", int'(s_c2x), 6);
        check("s_sweep2_c2y", int'(s_c2y), 2);
      end
    end
    if (!s_done) check("s_timeout", int'(s_done), 1);
    else begin
      check("s_latency", lat, 771);
      check("s_c1x", int'(s_c1x), 1);
      check("s_c1y", int'(s_c1y), 1);
      check("s_c2x", int'(s_c2x), 6);
      check("s_c2y", int'(s_c2y), 2);
      check("s_count", int'(s_count), 4);
    end
  endtask

  initial begin
    rst = 1'b1;
    d_valid = 1'b0; d_x = '0; d_y = '0;
    m_valid = 1'b0; m_x = '0; m_y = '0;
    s_valid = 1'b0; s_x = '0; s_y = '0;
    #12;
    check("rst_d_ready", int'(d_ready), 1);
    check("rst_d_done", int'(d_done), 0);
    check("rst_d_count", int'(d_count), 0);
    check("rst_d_c1x", int'(d_c1x), 0);
    check("rst_s_ready", int'(s_ready), 1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 40; i++) begin
      tx[i] = 7;
      ty[i] = 7;
    end
    load_d(1'b0);
    repeat (5000) @(posedge clk);
    #2;
    check("mid_sweep_ready", int'(d_ready), 0);
    rst = 1'b1;
    #1;
    check("async_rst_ready", int'(d_ready), 1);
    check("async_rst_done", int'(d_done), 0);
    check("async_rst_count", int'(d_count), 0);
    check("async_rst_c1", int'({d_c1x, d_c1y}), 0);
    check("async_rst_c2", int'({d_c2x, d_c2y}), 0);
    @(negedge clk);
    rst = 1'b0;

    fork
      begin
        load_d(1'b0);
        wait_d("same_pts", 20482, 7, 11, 0, 0, 40);
      end
      run_m();
      run_s();
    join

    check("hold_count", int'(d_count), 40);
    check("hold_c1y", int'(d_c1y), 11);
    for (int i = 0; i < 40; i++) begin
      tx[i] = (i < 20) ? 2 : 13;
      ty[i] = (i < 20) ? 2 : 13;
    end
    load_d(1'b0);
    wait_d("two_clusters", 20482, 15, 15, 0, 0, 40);

    for (int i = 0; i < 40; i++) begin
      tx[i] = 7;
      ty[i] = 7;
    end
    load_d(1'b1);
    d_valid = 1'b1;
    d_x = 4'd0;
    d_y = 4'd0;
    wait_d("stalled_load", 20482, 7, 11, 0, 0, 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
